uart_fifo_timer: RTL and testbench
==================================

// Module: uart_fifo_timer
// PURPOSE
//  Memory-mapped UART for the RV32I SoC. Buffered, runtime-programmable successor to the single-byte debug UART.
//  Adds TX/RX FIFOs of parametrised depth, a programmable baud divisor, sticky error flags,
//  an interrupt output and a writable, wrap-safe millisecond counter. Sits on the CPU data bus at 0x200000xx.
// PARAMETERS
//  DEFAULT_DIV   48      reset value of baud divisor, in clk_i cycles per bit (48 MHz / 48 = 1 Mb/s)
//  TX_AW         4       TX FIFO depth = 2**TX_AW bytes
//  RX_AW         4       RX FIFO depth = 2**RX_AW bytes
//  TICK_DIV      48000   clk_i cycles per ms_counter increment
// PORTS
//  clk_i     in   1   single clock; all logic is in this domain
//  rstn      in   1   asynchronous, active-low reset
//  m_sel     in   1   block select, decoded from the upper address
//  m_addr    in   4   word register index
//  m_data_i  in   32  write data
//  m_data_o  out  32  read data, combinational from m_addr; 0 when !m_sel
//  m_rd      in   1   read strobe; reads have no side effects
//  m_wr      in   1   write strobe; each cycle high is one write
//  RXD       in   1   serial input, asynchronous
//  TXD       out  1   serial output, idle high
//  irq_o     out  1   registered: (ien_rx & rx_nempty) | (ien_tx & tx_empty)
// BEHAVIOUR
//  Reset values: TXD=1, irq_o=0, both FIFOs empty, sticky flags=0, div=DEFAULT_DIV, ien=0, ms_counter=0.
//   RXD synchroniser (2 flops) resets to 1.
//  Register map:
//   0  R: RX head byte {24'b0,d} (0 if empty).  W: push m_data_i[7:0] to TX FIFO.
//   1  R: {..,par_err,frm_err,tx_ovf,rx_ovr,tx_empty,tx_nfull,rx_nempty}, bits [6:0].
//      W: bit0=1 pops RX; bit1=1 clears all sticky flags.
//   2  R/W: ms_counter.
//   3  R/W: [15:0] div (writes <4 are clamped to 4); [16] ien_rx; [17] ien_tx; [19:18] parity mode.
//   Other indices read 0; writes to them are ignored.
//  TX FSM IDLE->START->DATA(8, LSB first)->[PARITY]->STOP->IDLE. Each state lasts div cycles.
//   div is latched at START, so a divisor write mid-frame affects the next frame only.
//   A frame starts the cycle after the FIFO is non-empty.
//  RX FSM IDLE->START: entered after synced RXD has been low for div/2 cycles.
//   START falls back to IDLE if RXD is high when the start bit is resampled.
//   START->DATA(8)->[PARITY]->STOP, sampling at each bit centre (every div cycles).
//  RX STOP handling: stop=0 sets frm_err, and the byte is still pushed.
//   If the RX FIFO is full at push time, the byte is dropped and rx_ovr is set.
//  TX push while full: byte dropped, tx_ovf set.
//  Pop while empty: no effect.
//  Same-cycle push and pop on one FIFO: both occur, count unchanged.
//   When full, the pop frees the slot for the push, so no overflow is flagged.
//  Same-cycle sticky clear and new error: the error wins, flag stays 1.
//  ms counter: ms_timer counts 0..TICK_DIV-1; ms_counter += 1 on wrap and wraps 0xFFFFFFFF->0.
//   A write to reg 2 loads ms_counter and zeroes ms_timer in the same cycle.
//  Reset asserted mid-frame: TXD goes to 1 immediately and both FSMs go to IDLE.
//   FIFO contents are lost.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   reg3[19:18]: 00 none, 01 even, 10 odd, 11 treated as none.
//   A parity bit is sent/checked after data; a mismatch sets par_err and the byte is still pushed.
//  UART_PARITY_EN undefined:
//   No parity state; reg3[19:18] and par_err read 0 and writes are ignored; frame is always 8N1.
// TESTING
//  T1: write 0x55,0xA3 to reg0 at div=48 -> TXD shows 2 frames of 10 bits x 48 cycles, back-to-back.
//      tx_empty is set after the final stop bit.
//  T2: drive 20 frames on RXD with no pops, RX_AW=4 -> 16 bytes are stored and rx_ovr=1.
//      Then 16 pops return bytes 0..15 in order.
//  T3: write div=4 mid-frame, then queue a 2nd byte -> 1st frame keeps 48-cycle bits, 2nd uses 4.
//      A write of div=1 reads back 4.
//  T4: RXD frame with stop=0 -> byte is stored and frm_err=1.
//      Write reg1=0x2 -> frm_err=0.
//  T5: TICK_DIV=10, load reg2=0xFFFFFFFE -> reads 0xFFFFFFFF after 10 cycles and 0 after 20.
//  T6: assert rstn low in the middle of the TX data bits -> TXD=1 the same cycle, reg1 reads 0x6.
//      With UART_PARITY_EN: even mode, send 0x07 -> parity bit 1; corrupt it on RX -> par_err=1.

Source files
------------

// File: rtl/uart_fifo_timer_if.sv
// CPU data-bus port of the UART: block select, word index, write/read strobes and data.
interface uart_fifo_timer_if;
   logic        m_sel;
   logic [3:0]  m_addr;
   logic [31:0] m_data_i;
   logic [31:0] m_data_o;
   logic        m_rd;
   logic        m_wr;

   modport master (output m_sel, m_addr, m_data_i, m_rd, m_wr, input m_data_o);
   modport slave  (input m_sel, m_addr, m_data_i, m_rd, m_wr, output m_data_o);
endinterface

// File: rtl/uart_fifo_timer.sv
// Buffered UART with TX/RX FIFOs, programmable divisor, sticky errors, irq and a ms counter.
// Define UART_PARITY_EN to add the optional parity bit (reg3[19:18] mode, par_err flag).
module uart_fifo_timer #(
   parameter int DEFAULT_DIV = 48,
   parameter int TX_AW       = 4,
   parameter int RX_AW       = 4,
   parameter int TICK_DIV    = 48000
) (
   input  logic             clk_i,
   input  logic             rstn,
   uart_fifo_timer_if.slave bus,
   input  logic             RXD,
   output logic             TXD,
   output logic             irq_o
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_st_e;

   logic [15:0] div;
   logic        ien_rx, ien_tx;
   logic [1:0]  pmode;
   logic        rx_ovr, tx_ovf, frm_err, par_err;
   logic [31:0] ms_counter;
   logic [TW-1:0] ms_timer;
   logic        wr0, wr1, wr2, wr3, clr, unused_ok;

   assign wr0 = bus.m_sel & bus.m_wr & (bus.m_addr == 4'd0);
   assign wr1 = bus.m_sel & bus.m_wr & (bus.m_addr == 4'd1);
   assign wr2 = bus.m_sel & bus.m_wr & (bus.m_addr == 4'd2);
   assign wr3 = bus.m_sel & bus.m_wr & (bus.m_addr == 4'd3);
   assign clr = wr1 & bus.m_data_i[1];
   assign unused_ok = ^{bus.m_rd, bus.m_data_i[31:16]};

   // ---------------- FIFOs: count is one bit wider so full == MSB set
   logic [7:0]       tx_mem [2**TX_AW];
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic [TX_AW:0]   tx_cnt;
   logic             tx_fempty, tx_full, tx_pop, tx_push_ok, tx_empty;
   logic [7:0]       rx_mem [2**RX_AW];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic [RX_AW:0]   rx_cnt;
   logic             rx_fempty, rx_full, rx_pop, rx_push, rx_push_ok;
   logic [7:0]       rx_head;

   uart_st_e    tx_st, rx_st;
   logic [15:0] tcnt, tdiv, rcnt, rdiv;
   logic [2:0]  tbit, rbit;
   logic [7:0]  tsh, rsh;
   logic [1:0]  tpm, rpm;
   logic        tpar_on, rpar_on, rpar_bad, armed, rxs;
   logic [1:0]  rx_sync;

   assign tx_fempty  = (tx_cnt == '0);
   assign tx_full    = tx_cnt[TX_AW];
   assign tx_pop     = ~tx_fempty & ((tx_st == S_IDLE) | ((tx_st == S_STOP) & (tcnt == '0)));
   assign tx_push_ok = wr0 & (~tx_full | tx_pop);
   assign tx_empty   = tx_fempty & (tx_st == S_IDLE);
   assign rx_fempty  = (rx_cnt == '0);
   assign rx_full    = rx_cnt[RX_AW];
   assign rx_pop     = wr1 & bus.m_data_i[0] & ~rx_fempty;
   assign rx_push    = (rx_st == S_STOP) & (rcnt == '0);
   assign rx_push_ok = rx_push & (~rx_full | rx_pop);
   assign rx_head    = rx_fempty ? 8'h00 : rx_mem[rx_rp];

   always_ff @(posedge clk_i) begin
      if (tx_push_ok) tx_mem[tx_wp] <= bus.m_data_i[7:0];
      if (rx_push_ok) rx_mem[rx_wp] <= rsh;
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
         rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else begin
         if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)     tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + {{TX_AW{1'b0}}, tx_push_ok} - {{TX_AW{1'b0}}, tx_pop};
         if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)     rx_rp <= rx_rp + 1'b1;
         rx_cnt <= rx_cnt + {{RX_AW{1'b0}}, rx_push_ok} - {{RX_AW{1'b0}}, rx_pop};
      end
   end

   // ---------------- control registers, sticky flags (a new error beats a clear), irq, ms counter
   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         div <= 16'(DEFAULT_DIV); ien_rx <= 1'b0; ien_tx <= 1'b0;
         rx_ovr <= 1'b0; tx_ovf <= 1'b0; frm_err <= 1'b0; par_err <= 1'b0;
         irq_o <= 1'b0; ms_counter <= '0; ms_timer <= '0;
      end else begin
         if (wr3) begin
            div    <= (bus.m_data_i[15:0] < 16'd4) ? 16'd4 : bus.m_data_i[15:0];
            ien_rx <= bus.m_data_i[16];
            ien_tx <= bus.m_data_i[17];
         end
         rx_ovr  <= (rx_ovr  & ~clr) | (rx_push & rx_full & ~rx_pop);
         tx_ovf  <= (tx_ovf  & ~clr) | (wr0 & tx_full & ~tx_pop);
         frm_err <= (frm_err & ~clr) | (rx_push & ~rxs);
         par_err <= (par_err & ~clr) | (rx_push & rpar_bad);
         irq_o   <= (ien_rx & ~rx_fempty) | (ien_tx & tx_empty);
         if (wr2) begin
            ms_counter <= bus.m_data_i;
            ms_timer   <= '0;
         end else if (ms_timer == TW'(TICK_DIV - 1)) begin
            ms_timer   <= '0;
            ms_counter <= ms_counter + 32'd1;
         end else begin
            ms_timer <= ms_timer + TW'(1);
         end
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn)    pmode <= 2'b00;
      else if (wr3) pmode <= bus.m_data_i[19:18];
   end
`else
   assign pmode = 2'b00;
`endif

   // mode 11 behaves as no parity; odd parity is even parity inverted
   assign tpar_on = (tpm == 2'b01) | (tpm == 2'b10);
   assign rpar_on = (rpm == 2'b01) | (rpm == 2'b10);

   // ---------------- TX: divisor and parity mode are frozen for the whole frame
   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         tx_st <= S_IDLE; TXD <= 1'b1; tcnt <= '0; tdiv <= 16'd4;
         tbit <= '0; tsh <= '0; tpm <= 2'b00;
      end else if (tx_pop) begin
         tx_st <= S_START; TXD <= 1'b0; tsh <= tx_mem[tx_rp];
         tdiv <= div; tcnt <= div - 16'd1; tpm <= pmode;
      end else if (tx_st != S_IDLE) begin
         if (tcnt != '0) tcnt <= tcnt - 16'd1;
         else begin
            tcnt <= tdiv - 16'd1;
            case (tx_st)
               S_START: begin tx_st <= S_DATA; tbit <= '0; TXD <= tsh[0]; end
               S_DATA:
                  if (tbit != 3'd7) begin
                     tbit <= tbit + 3'd1; TXD <= tsh[tbit + 3'd1];
                  end else if (tpar_on) begin
                     tx_st <= S_PAR; TXD <= ^tsh ^ tpm[1];
                  end else begin
                     tx_st <= S_STOP; TXD <= 1'b1;
                  end
               S_PAR:   begin tx_st <= S_STOP; TXD <= 1'b1; end
               default: begin tx_st <= S_IDLE; TXD <= 1'b1; end
            endcase
         end
      end
   end

   // ---------------- RX: start needs a fresh high->low after each frame (armed)
   assign rxs = rx_sync[1];

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         rx_sync <= 2'b11; rx_st <= S_IDLE; rcnt <= '0; rdiv <= 16'd4;
         rbit <= '0; rsh <= '0; rpm <= 2'b00; rpar_bad <= 1'b0; armed <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], RXD};
         case (rx_st)
            S_IDLE:
               if (rxs) begin
                  armed <= 1'b1; rcnt <= '0;
               end else if (armed) begin
                  if (rcnt == {1'b0, div[15:1]} - 16'd1) begin
                     rx_st <= S_START; rdiv <= div; rpm <= pmode; rpar_bad <= 1'b0;
                  end else rcnt <= rcnt + 16'd1;
               end
            S_START:
               if (rxs) rx_st <= S_IDLE;
               else begin rx_st <= S_DATA; rbit <= '0; rcnt <= rdiv - 16'd2; end
            default:
               if (rcnt != '0) rcnt <= rcnt - 16'd1;
               else begin
                  rcnt <= rdiv - 16'd1;
                  case (rx_st)
                     S_DATA: begin
                        rsh <= {rxs, rsh[7:1]};
                        if (rbit == 3'd7) rx_st <= rpar_on ? S_PAR : S_STOP;
                        else rbit <= rbit + 3'd1;
                     end
                     S_PAR:   begin rpar_bad <= rxs ^ ^rsh ^ rpm[1]; rx_st <= S_STOP; end
                     default: begin rx_st <= S_IDLE; armed <= 1'b0; rcnt <= '0; end
                  endcase
               end
         endcase
      end
   end

   // ---------------- read mux, reads are side-effect free
   always_comb begin
      bus.m_data_o = '0;
      if (bus.m_sel) begin
         case (bus.m_addr)
            4'd0: bus.m_data_o = {24'b0, rx_head};
            4'd1: bus.m_data_o = {25'b0, par_err, frm_err, tx_ovf, rx_ovr, tx_empty, ~tx_full, ~rx_fempty};
            4'd2: bus.m_data_o = ms_counter;
            4'd3: bus.m_data_o = {12'b0, pmode, ien_tx, ien_rx, div};
            default: bus.m_data_o = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_timer.sv
// Randomised bench for uart_fifo_timer: TX frame decoder, RX byte queue model, ms counter arithmetic.
`timescale 1ns/1ps
module tb_uart_fifo_timer;
   localparam int TICK = 10;
   logic clk_i = 1'b0, rstn = 1'b0, RXD = 1'b1;
   logic TXD, irq_o;

   uart_fifo_timer_if bus();
   uart_fifo_timer #(.DEFAULT_DIV(48), .TX_AW(4), .RX_AW(4), .TICK_DIV(TICK)) dut (
      .clk_i(clk_i), .rstn(rstn), .bus(bus), .RXD(RXD), .TXD(TXD), .irq_o(irq_o));

   always #5 clk_i = ~clk_i;

   int checks = 0, failures = 0;
   int tx_frames = 0, tx_negs = 0, mon_pm = 0;
   bit mon_skip = 1'b0;
   logic [7:0] tx_exp_q[$];
   int         tx_div_q[$];
   int         tx_starts[$];
   logic [7:0] rxq[$];
   logic m_rxovr = 0, m_txovf = 0, m_frm = 0, m_par = 0;

   function automatic int now_cyc();
      return int'($time / 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(posedge clk_i); #1;
      bus.m_sel = 1'b1; bus.m_wr = 1'b1; bus.m_addr = a; bus.m_data_i = d;
      @(posedge clk_i); #1;
      bus.m_sel = 1'b0; bus.m_wr = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      bus.m_sel = 1'b1; bus.m_rd = 1'b1; bus.m_addr = a;
      #1 d = bus.m_data_o;
      bus.m_sel = 1'b0; bus.m_rd = 1'b0;
   endtask

   function automatic logic [31:0] exp_r1();
      return {25'b0, m_par, m_frm, m_txovf, m_rxovr, 1'b1, 1'b1, rxq.size() != 0};
   endfunction

   task automatic tx_byte(input logic [7:0] b, input int d);
      tx_exp_q.push_back(b); tx_div_q.push_back(d);
      wr(0, {24'b0, b});
   endtask

   // poll tx_empty; returns the cycle it was first seen set
   task automatic wait_tx_idle(input string tag, input int budget, output int t);
      logic [31:0] r;
      t = -1;
      for (int i = 0; i < budget && t < 0; i++) begin
         cyc(1); rd(1, r);
         if (r[2]) t = now_cyc();
      end
      if (t < 0) chk(tag, 0, 1);
   endtask

   // serial RX frame; the model stores it unless the 16-deep queue is full
   task automatic rx_send(input logic [7:0] b, input int d, input logic stopv, input int pm, input logic flip);
      RXD = 1'b0; cyc(d);
      for (int i = 0; i < 8; i++) begin RXD = b[i]; cyc(d); end
      if (pm == 1 || pm == 2) begin RXD = (^b) ^ (pm == 2) ^ flip; cyc(d); end
      RXD = stopv; cyc(d);
      RXD = 1'b1; cyc(2 * d);
      if (rxq.size() < 16) rxq.push_back(b); else m_rxovr = 1'b1;
      if (!stopv) m_frm = 1'b1;
      if (flip && (pm == 1 || pm == 2)) m_par = 1'b1;
   endtask

   // TXD frame decoder
   initial begin : mon
      logic [7:0] got, e;
      int d;
      forever begin
         @(negedge TXD);
         tx_negs++;
         if (mon_skip) continue;
         tx_starts.push_back(now_cyc());
         chk("tx_exp_avail", 32'(tx_exp_q.size() != 0), 1);
         if (tx_exp_q.size() == 0) continue;
         e = tx_exp_q.pop_front(); d = tx_div_q.pop_front();
         cyc(d / 2); chk("tx_start", TXD, 0);
         for (int i = 0; i < 8; i++) begin cyc(d); got[i] = TXD; end
         if (mon_pm == 1 || mon_pm == 2) begin
            cyc(d); chk("tx_par", TXD, 32'((^e) ^ (mon_pm == 2)));
         end
         cyc(d); chk("tx_stop", TXD, 1);
         chk("tx_byte", got, e);
         tx_frames++;
      end
   end

   initial begin : main
      logic [31:0] r, v;
      logic [7:0] b;
      int t, n, d, f0, negs0;
      bus.m_sel = 0; bus.m_wr = 0; bus.m_rd = 0; bus.m_addr = 0; bus.m_data_i = 0;
      cyc(3); rstn = 1'b1; cyc(1);

      // reset state
      rd(1, r); chk("rst_r1", r, 32'h6);
      rd(3, r); chk("rst_r3", r, 32'd48);
      rd(0, r); chk("rst_r0", r, 0);
      rd(2, r); chk("rst_r2", r, 0);
      rd(7, r); chk("rst_r7", r, 0);
      chk("rst_txd", TXD, 1); chk("rst_irq", irq_o, 0);

      // two back-to-back frames at div 48
      tx_byte(8'h55, 48); tx_byte(8'hA3, 48);
      rd(1, r); chk("t1_busy", r[2], 0);
      wait_tx_idle("t1_timeout", 2000, t);
      chk("t1_frames", tx_frames, 2);
      if (tx_starts.size() >= 2) begin
         chk("t1_gap", tx_starts[1] - tx_starts[0], 480);
         chk("t1_empty_at", t - tx_starts[1], 480);
      end else chk("t1_starts", tx_starts.size(), 2);

      // random bytes at div 8
      wr(3, 8);
      for (int i = 0; i < 3; i++) tx_byte(8'($urandom), 8);
      wait_tx_idle("txr_timeout", 400, t);
      chk("txr_frames", tx_frames, 5);

      // divisor change mid-frame only affects the next frame; clamp
      wr(3, 48); tx_byte(8'($urandom), 48);
      cyc(100); wr(3, 4); tx_byte(8'($urandom), 4);
      wait_tx_idle("t3_timeout", 1000, t);
      chk("t3_frames", tx_frames, 7);
      wr(3, 1); rd(3, r); chk("t3_clamp", r[15:0], 4);

      // irq from tx_empty
      wr(3, 32'h2_0008); cyc(1); chk("irq_tx_on", irq_o, 1);
      wr(3, 32'h0_0008); cyc(1); chk("irq_tx_off", irq_o, 0);

      // TX overflow: one byte in flight plus 16 queued, the 18th is dropped
      wr(3, 16); f0 = tx_frames;
      for (int i = 0; i < 18; i++) begin
         b = 8'($urandom);
         if (i < 17) tx_byte(b, 16); else wr(0, {24'b0, b});
      end
      m_txovf = 1'b1;
      rd(1, r); chk("txovf_flag", r[4], 1); chk("txovf_nfull", r[1], 0);
      wait_tx_idle("txovf_timeout", 3200, t);
      chk("txovf_frames", tx_frames - f0, 17);
      wr(1, 2); m_txovf = 1'b0;
      rd(1, r); chk("txovf_clr", r, exp_r1());

      // RX overrun: 20 frames, 16 kept
      d = $urandom_range(6, 12); wr(3, d);
      for (int i = 0; i < 20; i++) rx_send(8'($urandom), d, 1'b1, 0, 1'b0);
      rd(1, r); chk("rx_r1_full", r, exp_r1());
      wr(3, d | 32'h1_0000); cyc(1); chk("irq_rx_on", irq_o, 1);
      for (int i = 0; i < 16; i++) begin
         rd(0, r); chk("rx_pop", r, {24'b0, rxq.pop_front()});
         wr(1, 1);
      end
      rd(0, r); chk("rx_empty_r0", r, 0);
      wr(1, 1);
      rd(1, r); chk("rx_pop_empty", r, exp_r1());
      cyc(1); chk("irq_rx_off", irq_o, 0);
      wr(1, 2); m_rxovr = 1'b0;
      rd(1, r); chk("rx_ovr_clr", r, exp_r1());

      // framing error: byte kept, flag sticky until cleared
      b = 8'($urandom); rx_send(b, d, 1'b0, 0, 1'b0);
      rd(1, r); chk("frm_set", r, exp_r1());
      rd(0, r); chk("frm_byte", r, {24'b0, b});
      wr(1, 3); void'(rxq.pop_front()); m_frm = 1'b0;
      rd(1, r); chk("frm_clr", r, exp_r1());
      b = 8'($urandom); rx_send(b, d, 1'b1, 0, 1'b0);
      rd(0, r); chk("rx_after_frm", r, {24'b0, rxq.pop_front()});
      wr(1, 1);

`ifdef UART_PARITY_EN
      wr(3, 32'h4_0008); rd(3, r); chk("par_mode_rb", r[19:16], 4'b0100);
      mon_pm = 1; tx_byte(8'h07, 8);
      wait_tx_idle("par_tx_timeout", 400, t);
      mon_pm = 0;
      rx_send(8'h07, 8, 1'b1, 1, 1'b1);
      rd(1, r); chk("par_err_set", r, exp_r1());
      rd(0, r); chk("par_byte", r, 32'h07);
      wr(1, 3); void'(rxq.pop_front()); m_par = 1'b0;
      wr(3, 32'h8_0008);
      b = 8'($urandom); rx_send(b, 8, 1'b1, 2, 1'b0);
      rd(1, r); chk("par_odd_ok", r, exp_r1());
      rd(0, r); chk("par_odd_byte", r, {24'b0, rxq.pop_front()});
      wr(1, 1); wr(3, 8);
`else
      wr(3, 32'h4_0008); rd(3, r); chk("par_mode_ro", r[19:16], 4'b0000);
`endif

      // ms counter: wrap at 0xFFFFFFFF, then random loads
      wr(2, 32'hFFFF_FFFE);
      cyc(9); rd(2, r); chk("ms_9", r, 32'hFFFF_FFFE);
      cyc(1); rd(2, r); chk("ms_10", r, 32'hFFFF_FFFF);
      cyc(10); rd(2, r); chk("ms_20", r, 0);
      for (int i = 0; i < 4; i++) begin
         v = $urandom; n = $urandom_range(1, 60);
         wr(2, v); cyc(n); rd(2, r); chk("ms_rand", r, v + 32'(n / TICK));
      end

      // reset in the middle of data bits: TXD high at once, queued byte lost
      wr(3, 48); mon_skip = 1'b1;
      wr(0, 0); wr(0, 0);
      cyc(48 * 4); chk("t6_pre_txd", TXD, 0);
      #2 rstn = 1'b0;
      #1 chk("t6_txd_now", TXD, 1);
      cyc(2); rstn = 1'b1; cyc(1);
      rd(1, r); chk("t6_r1", r, 32'h6);
      rd(3, r); chk("t6_r3", r, 32'd48);
      negs0 = tx_negs;
      cyc(600);
      chk("t6_no_frame", tx_negs - negs0, 0);
      chk("t6_txd_idle", TXD, 1);
      mon_skip = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
